button_stepper: RTL and testbench
=================================

# button_stepper

Converts the debounced level outputs of two `button_debouncer` instances (up/down) into a bounded, saturating parameter value for the scope front-end, such as the timebase index or the trigger level. A single press steps the value once. Holding a button auto-repeats after a programmable delay, and pressing both buttons together locks out stepping until both are released.

## Interface
- `WIDTH`, 8 — value width in bits.
- `MIN_VAL`, 0 — lower clamp. The requirement is MIN_VAL ≤ RESET_VAL ≤ MAX_VAL ≤ 2^WIDTH−1.
- `MAX_VAL`, 255 — upper clamp.
- `RESET_VAL`, 128 — value loaded on reset.
- `clock` in 1 — the only clock; all state changes on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `btn_up` in 1 — debounced level, synchronous to `clock`.
- `btn_down` in 1 — debounced level, synchronous to `clock`.
- `step` in WIDTH — increment/decrement magnitude, sampled at every step edge.
- `repeat_delay` in 24 — extra cycles from the initial step to the first repeat.
- `repeat_period` in 24 — extra cycles between repeat steps.
- `value` out WIDTH — current parameter value (registered).
- `changed` out 1 — one-cycle pulse, registered, high in the cycle after any edge that altered `value`.
- `at_min` out 1 — registered; high when `value` == MIN_VAL.
- `at_max` out 1 — registered; high when `value` == MAX_VAL.

## Operation
- The state machine has four states: IDLE, DELAY, REPEAT, LOCK. A 24-bit counter `cnt` runs alongside it. `dir` records the active button.
- IDLE:
  - If exactly one button is high: step once in that direction, set `dir`, clear `cnt`, go to DELAY.
  - If both buttons are high: go to LOCK with no step.
  - If neither is high: stay in IDLE.
- DELAY:
  - If the `dir` button goes low: go to IDLE. This check has priority over everything else in the state.
  - Else if the other button goes high: go to LOCK.
  - Else if `cnt` == `repeat_delay`: step, clear `cnt`, go to REPEAT.
  - Otherwise: increment `cnt`.
- REPEAT: same release and lock rules as DELAY. When `cnt` == `repeat_period`: step and clear `cnt`; otherwise increment `cnt`.
- LOCK: no steps. Go to IDLE only in a cycle where both buttons are low.
- Step up: new value = min(value + step, MAX_VAL). Compute the sum at WIDTH+1 bits so it cannot wrap.
- Step down: if value − MIN_VAL < step, new value = MIN_VAL; otherwise new value = value − step. This never underflows.
- `changed` asserts only when the new value differs from the old one:
  - A step at a clamp produces no pulse.
  - `step` = 0 produces no pulse.
  - The state and counter still advance normally in both cases.
- `at_min` and `at_max` update on the same edge as `value`.
- `repeat_delay` and `repeat_period` are compared live. Changing them mid-hold takes effect at the next comparison. If `cnt` is already past the new target, it keeps counting and wraps at 2^24.
- A button already high when reset deasserts is treated as a fresh press: one step on the first edge after reset.

## Timing
- Reset values: `value` = RESET_VAL, `changed` = 0, `at_min` = (RESET_VAL == MIN_VAL), `at_max` = (RESET_VAL == MAX_VAL). State is IDLE and `cnt` = 0.
- Reset has priority over all other inputs on the same edge.
- Initial step latency: when a button is high before edge k while in IDLE, `value` and `changed` are updated at edge k (visible in the cycle after edge k).
- First repeat: repeat_delay+1 edges after the initial step edge.
- Subsequent repeats: every repeat_period+1 edges. With `repeat_period` = 0 the block steps on every edge.
- Release: the `dir` button low before edge j means no step at edge j, and the state is IDLE after edge j. A new press can step at edge j+1 at the earliest.
- Simultaneous events in DELAY/REPEAT at an edge where `cnt` hits its target: release beats the other button rising, which beats the step.
- `changed` never stays high for two consecutive cycles unless steps occur on consecutive edges (`repeat_period` = 0).

## Test plan
- Reset with RESET_VAL = 128, `step` = 1, then `btn_up` high for exactly 1 cycle → `value` = 129, `changed` high for 1 cycle, state back to IDLE.
- Hold `btn_up` with `repeat_delay` = 10, `repeat_period` = 3, `step` = 2 → steps at edges 0, 11, 15, 19; `value` goes 130, 132, 134, 136.
- Start at 250 with MAX_VAL = 255, `step` = 4, `repeat_period` = 0, hold `btn_up` → `value` goes 254, 255, 255…; `changed` pulses twice only; `at_max` = 1.
- Start at 3 with MIN_VAL = 0, `step` = 5, press `btn_down` → `value` = 0, `at_min` = 1, `changed` = 1; a second press gives `changed` = 0.
- Hold `btn_up`, then raise `btn_down` mid-DELAY → no further steps. Release `btn_up` only → still locked. Release both → IDLE. Next `btn_down` press → one step down.
- Assert `reset` during REPEAT while `btn_up` is held → `value` = RESET_VAL on that edge. First edge after reset deasserts → `value` = RESET_VAL + `step`.

Source files
------------

// File: rtl/button_stepper.sv
// Turns debounced up/down button levels into a saturating parameter value with
// single-step presses, hold-to-repeat and a both-buttons lockout.
module button_stepper #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 255,
    parameter int unsigned RESET_VAL = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [WIDTH-1:0] step,
    input  logic [23:0]      repeat_delay,
    input  logic [23:0]      repeat_period,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_V};

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

    state_t           state, state_next;
    logic [23:0]      cnt, cnt_next;
    logic             dir, dir_next;     // 1 = up, 0 = down
    logic             do_step;
    logic             step_up;
    logic             dir_btn, other_btn;
    logic [23:0]      target;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] up_val, down_val, new_val, value_next;

    assign dir_btn   = dir ? btn_up : btn_down;
    assign other_btn = dir ? btn_down : btn_up;
    assign target    = (state == DELAY) ? repeat_delay : repeat_period;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir;
        do_step    = 1'b0;
        step_up    = dir;
        unique case (state)
            IDLE: begin
                if (btn_up ^ btn_down) begin
                    do_step    = 1'b1;
                    step_up    = btn_up;
                    dir_next   = btn_up;
                    cnt_next   = '0;
                    state_next = DELAY;
                end else if (btn_up && btn_down) begin
                    state_next = LOCK;
                end
            end
            DELAY, REPEAT: begin
                // Release outranks the lockout, which outranks a due step.
                if (!dir_btn) begin
                    state_next = IDLE;
                end else if (other_btn) begin
                    state_next = LOCK;
                end else if (cnt == target) begin
                    do_step    = 1'b1;
                    cnt_next   = '0;
                    state_next = REPEAT;
                end else begin
                    cnt_next = cnt + 24'd1;
                end
            end
            LOCK: begin
                if (!btn_up && !btn_down)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The extra sum bit keeps the up step from wrapping before the clamp.
    assign sum_ext    = {1'b0, value} + {1'b0, step};
    assign up_val     = (sum_ext > MAX_EXT) ? MAX_V : sum_ext[WIDTH-1:0];
    assign down_val   = ((value - MIN_V) < step) ? MIN_V : value - step;
    assign new_val    = step_up ? up_val : down_val;
    assign value_next = do_step ? new_val : value;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dir     <= 1'b0;
            value   <= RESET_V;
            changed <= 1'b0;
            at_min  <= (RESET_V == MIN_V);
            at_max  <= (RESET_V == MAX_V);
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            dir     <= dir_next;
            value   <= value_next;
            changed <= (value_next != value);
            at_min  <= (value_next == MIN_V);
            at_max  <= (value_next == MAX_V);
        end
    end

endmodule

// File: tb/tb_button_stepper.sv
// Directed bench for button_stepper: reset, single press, hold/repeat timing,
// clamping at both ends, lockout and reset during a held button.
module tb_button_stepper;

    logic        clock;
    logic        reset;
    logic        btn_up, btn_down;
    logic [7:0]  step;
    logic [23:0] repeat_delay, repeat_period;
    logic [7:0]  value, value2;
    logic        changed, at_min, at_max;
    logic        changed2, at_min2, at_max2;

    int checks = 0;
    int errors = 0;

    button_stepper dut (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .step(step), .repeat_delay(repeat_delay), .repeat_period(repeat_period),
        .value(value), .changed(changed), .at_min(at_min), .at_max(at_max)
    );

    // Narrow-range instance that comes out of reset sitting on its lower clamp.
    button_stepper #(.WIDTH(8), .MIN_VAL(5), .MAX_VAL(20), .RESET_VAL(5)) dut2 (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .step(step), .repeat_delay(repeat_delay), .repeat_period(repeat_period),
        .value(value2), .changed(changed2), .at_min(at_min2), .at_max(at_max2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input int v, input int ch);
        check({tag, ".value"}, 32'(value), 32'(v));
        check({tag, ".changed"}, 32'(changed), 32'(ch));
    endtask

    int exp_v;
    int pulses;

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        step = 8'd1; repeat_delay = 24'd10; repeat_period = 24'd3;
        tick(); tick();
        reset = 1'b0;
        check_out("reset", 128, 0);
        check("reset.at_min", 32'(at_min), 0);
        check("reset.at_max", 32'(at_max), 0);
        check("reset2.value", 32'(value2), 5);
        check("reset2.at_min", 32'(at_min2), 1);
        check("reset2.at_max", 32'(at_max2), 0);

        // Single one-cycle press.
        btn_up = 1'b1; tick(); btn_up = 1'b0;
        check_out("tap", 129, 1);
        check("tap2.value", 32'(value2), 6);
        check("tap2.changed", 32'(changed2), 1);
        check("tap2.at_min", 32'(at_min2), 0);
        tick();
        check_out("tap_after", 129, 0);

        // Hold: steps at edges 0, 11, 15, 19.
        reset = 1'b1; tick(); reset = 1'b0;
        check_out("reset_again", 128, 0);
        step = 8'd2;
        btn_up = 1'b1;
        exp_v = 128;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 0 || e == 11 || e == 15 || e == 19) begin
                exp_v += 2;
                check_out($sformatf("hold_e%0d", e), exp_v, 1);
            end else begin
                check_out($sformatf("hold_e%0d", e), exp_v, 0);
            end
        end
        btn_up = 1'b0; tick();
        check_out("hold_release", 136, 0);

        // Climb to 250, then saturate at MAX with repeat_period = 0.
        step = 8'd114; btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
        check_out("to250", 250, 0);
        step = 8'd4; repeat_delay = 24'd0; repeat_period = 24'd0;
        btn_up = 1'b1;
        tick(); check_out("sat_e0", 254, 1);
        tick(); check_out("sat_e1", 255, 1);
        check("sat.at_max", 32'(at_max), 1);
        pulses = 0;
        for (int e = 2; e < 8; e++) begin
            tick();
            if (changed) pulses++;
            check($sformatf("sat_e%0d.value", e), 32'(value), 255);
        end
        check("sat.extra_pulses", 32'(pulses), 0);
        btn_up = 1'b0; tick();

        // Down to 3, then clamp at MIN.
        step = 8'd252; btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
        check_out("to3", 3, 0);
        step = 8'd5;
        btn_down = 1'b1; tick(); btn_down = 1'b0;
        check_out("min_first", 0, 1);
        check("min.at_min", 32'(at_min), 1);
        check("min.at_max", 32'(at_max), 0);
        tick();
        btn_down = 1'b1; tick(); btn_down = 1'b0;
        check_out("min_second", 0, 0);
        tick();

        // Lockout mid-DELAY.
        step = 8'd1; repeat_delay = 24'd10; repeat_period = 24'd3;
        btn_up = 1'b1; tick();
        check_out("lock_press", 1, 1);
        tick(); tick();
        btn_down = 1'b1;
        for (int e = 0; e < 15; e++) tick();
        check_out("lock_both", 1, 0);
        btn_up = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        check_out("lock_down_only", 1, 0);
        btn_down = 1'b0; tick();
        check_out("lock_release", 1, 0);
        btn_down = 1'b1; tick(); btn_down = 1'b0;
        check_out("after_lock", 0, 1);
        tick();

        // Reset while repeating, with the button still held afterwards.
        step = 8'd3; repeat_delay = 24'd0; repeat_period = 24'd1;
        btn_up = 1'b1;
        tick(); check_out("rep_e0", 3, 1);
        tick(); check_out("rep_e1", 6, 1);
        tick(); check_out("rep_e2", 6, 0);
        tick(); check_out("rep_e3", 9, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check_out("rep_reset", 128, 0);
        tick();
        check_out("rep_after_reset", 131, 1);
        btn_up = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
